// File: rtl/strobe_decoder_pkg.sv
// Shared types and helpers for the strobe decoder and its one-hot sub-decoder.
package strobe_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Maps a logical "line is active" bit onto the physical output level.
  function automatic logic applyPolarity(input logic isActive, input logic activeLow);
    return isActive ^ activeLow;
  endfunction

endpackage

// File: rtl/strobe_decoder_onehot_decoder.sv
// Combinational select-to-one-hot decoder with an enable and selectable output polarity.
module onehot_decoder
  import strobe_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_en,
  output logic [2**SEL_W-1:0]   o_y
);

  localparam int   N_OUT   = 2**SEL_W;
  localparam logic ACT_LOW = (ACTIVE_LOW != 0);

  // Drive the selected line active when enabled; every other line sits at the idle level.
  always_comb begin
    o_y = {N_OUT{ACT_LOW}};
    for (int i = 0; i < N_OUT; i++) begin
      o_y[i] = applyPolarity(i_en && (i_sel == SEL_W'(i)), ACT_LOW);
    end
  end

endmodule

// File: rtl/strobe_decoder.sv
// Registered N-line strobe decoder with 74x138-style enable gating, ready/valid
// request port, programmable pulse length and an auto-scan mode.
module strobe_decoder
  import strobe_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int PULSE_LEN  = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_g1,
  input  logic [1:0]            en_g2_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [2**SEL_W-1:0]   y,
  output logic                  busy,
  output logic [SEL_W-1:0]      idx,
  output logic                  done
);

  localparam int                N_OUT      = 2**SEL_W;
  localparam int                PCNT_W     = $clog2(PULSE_LEN + 1);
  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_LEN - 1);
  localparam logic [SEL_W:0]    STEP_LAST  = (SEL_W + 1)'(N_OUT - 1);
  localparam logic [N_OUT-1:0]  Y_IDLE     = {N_OUT{ACTIVE_LOW != 0}};

  state_e              r_state;
  logic [SEL_W-1:0]    r_idx;
  logic [PCNT_W-1:0]   r_pulseCnt;
  logic [SEL_W:0]      r_stepCnt;
  logic                r_done;
  logic [N_OUT-1:0]    r_y;

  state_e              w_nextState;
  logic [SEL_W-1:0]    w_nextIdx;
  logic [PCNT_W-1:0]   w_nextPulse;
  logic [SEL_W:0]      w_nextStep;
  logic                w_nextDone;
  logic [N_OUT-1:0]    w_yNext;
  logic                w_enable;

  assign w_enable  = en_g1 & ~en_g2_n[0] & ~en_g2_n[1];
  assign req_ready = (r_state == IDLE) & w_enable;
  assign y         = r_y;
  assign busy      = (r_state != IDLE);
  assign idx       = r_idx;
  assign done      = r_done;

  // Next-state logic: accept in IDLE, time each pulse, step through lines in SCAN,
  // and abort straight to IDLE whenever the enable gate drops mid-sequence.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_nextPulse = r_pulseCnt;
    w_nextStep  = r_stepCnt;
    w_nextDone  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid && req_ready) begin
          w_nextIdx   = sel;
          w_nextPulse = '0;
          w_nextStep  = '0;
          unique case (mode)
            MODE_SINGLE: w_nextState = STROBE;
            MODE_SCAN:   w_nextState = SCAN;
          endcase
        end
      end
      STROBE: begin
        if (!w_enable) begin
          w_nextState = IDLE;
        end else if (r_pulseCnt == PULSE_LAST) begin
          w_nextState = IDLE;
          w_nextDone  = 1'b1;
        end else begin
          w_nextPulse = r_pulseCnt + 1'b1;
        end
      end
      SCAN: begin
        if (!w_enable) begin
          w_nextState = IDLE;
        end else if (r_pulseCnt == PULSE_LAST) begin
          w_nextPulse = '0;
          if (r_stepCnt == STEP_LAST) begin
            w_nextState = IDLE;
            w_nextDone  = 1'b1;
          end else begin
            w_nextStep = r_stepCnt + 1'b1;
            w_nextIdx  = r_idx + 1'b1;
          end
        end else begin
          w_nextPulse = r_pulseCnt + 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Decode the line for the coming cycle so the registered strobe is glitch-free.
  onehot_decoder #(
    .SEL_W      (SEL_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_decoder (
    .i_sel (w_nextIdx),
    .i_en  (w_nextState != IDLE),
    .o_y   (w_yNext)
  );

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_pulseCnt <= '0;
      r_stepCnt  <= '0;
      r_done     <= 1'b0;
      r_y        <= Y_IDLE;
    end else begin
      r_state    <= w_nextState;
      r_idx      <= w_nextIdx;
      r_pulseCnt <= w_nextPulse;
      r_stepCnt  <= w_nextStep;
      r_done     <= w_nextDone;
      r_y        <= w_yNext;
    end
  end

endmodule

// File: tb/tb_strobe_decoder.sv
// Bench for strobe_decoder: three configurations share one stimulus stream and are
// compared every cycle against a plan-based model (remaining cycles + start line).
module tb_strobe_decoder;

  logic        clk;
  logic        rst_n;
  logic        en_g1;
  logic [1:0]  en_g2_n;
  logic        mode;
  logic [3:0]  sel;
  logic        req_valid;

  logic        ready0, ready1, ready2;
  logic [7:0]  y0, y1;
  logic [15:0] y2;
  logic        busy0, busy1, busy2;
  logic [2:0]  idx0, idx1;
  logic [3:0]  idx2;
  logic        done0, done1, done2;

  logic [15:0] readyObs [3];
  logic [15:0] yObs     [3];
  logic [15:0] busyObs  [3];
  logic [15:0] idxObs   [3];
  logic [15:0] doneObs  [3];

  int total = 0;
  int bad   = 0;

  // Per-configuration constants: line count, pulse length, active-low flag.
  int nM  [3] = '{8, 8, 16};
  int plM [3] = '{1, 3, 2};
  int alM [3] = '{1, 1, 0};

  // Model state: cycles of strobing left, first line, planned length, scan flag, idx, done.
  int remainM [3];
  int startM  [3];
  int totalM  [3];
  int scanM   [3];
  int idxM    [3];
  int doneM   [3];

  strobe_decoder #(.SEL_W(3), .PULSE_LEN(1), .ACTIVE_LOW(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en_g1(en_g1), .en_g2_n(en_g2_n), .mode(mode),
    .sel(sel[2:0]), .req_valid(req_valid), .req_ready(ready0), .y(y0),
    .busy(busy0), .idx(idx0), .done(done0));

  strobe_decoder #(.SEL_W(3), .PULSE_LEN(3), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_g1(en_g1), .en_g2_n(en_g2_n), .mode(mode),
    .sel(sel[2:0]), .req_valid(req_valid), .req_ready(ready1), .y(y1),
    .busy(busy1), .idx(idx1), .done(done1));

  strobe_decoder #(.SEL_W(4), .PULSE_LEN(2), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en_g1(en_g1), .en_g2_n(en_g2_n), .mode(mode),
    .sel(sel), .req_valid(req_valid), .req_ready(ready2), .y(y2),
    .busy(busy2), .idx(idx2), .done(done2));

  assign readyObs[0] = {15'd0, ready0};
  assign readyObs[1] = {15'd0, ready1};
  assign readyObs[2] = {15'd0, ready2};
  assign yObs[0]     = {8'd0, y0};
  assign yObs[1]     = {8'd0, y1};
  assign yObs[2]     = y2;
  assign busyObs[0]  = {15'd0, busy0};
  assign busyObs[1]  = {15'd0, busy1};
  assign busyObs[2]  = {15'd0, busy2};
  assign idxObs[0]   = {13'd0, idx0};
  assign idxObs[1]   = {13'd0, idx1};
  assign idxObs[2]   = {12'd0, idx2};
  assign doneObs[0]  = {15'd0, done0};
  assign doneObs[1]  = {15'd0, done1};
  assign doneObs[2]  = {15'd0, done2};

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line being strobed in the current cycle, derived from elapsed time in the plan.
  function automatic int currentLine(input int d);
    int elapsed;
    elapsed = totalM[d] - remainM[d];
    if (scanM[d] != 0) return (startM[d] + elapsed / plM[d]) % nM[d];
    return startM[d];
  endfunction

  function automatic logic [15:0] expectedY(input int d);
    logic [15:0] v;
    int line;
    v = '0;
    line = currentLine(d);
    for (int i = 0; i < nM[d]; i++) begin
      if (remainM[d] > 0 && i == line) v[i] = (alM[d] == 0);
      else                             v[i] = (alM[d] != 0);
    end
    return v;
  endfunction

  task automatic modelEdge(input logic r, input logic en, input logic m, input int s, input logic v);
    for (int d = 0; d < 3; d++) begin
      doneM[d] = 0;
      if (!r) begin
        remainM[d] = 0;
        idxM[d]    = 0;
      end else if (remainM[d] > 0) begin
        if (!en) begin
          remainM[d] = 0;
        end else begin
          remainM[d]--;
          if (remainM[d] == 0) doneM[d] = 1;
          else                 idxM[d]  = currentLine(d);
        end
      end else if (v && en) begin
        startM[d]  = s % nM[d];
        scanM[d]   = m ? 1 : 0;
        totalM[d]  = m ? nM[d] * plM[d] : plM[d];
        remainM[d] = totalM[d];
        idxM[d]    = startM[d];
      end
    end
  endtask

  task automatic checkAll();
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("y%0d", d),    yObs[d],    expectedY(d));
      checkOutput($sformatf("busy%0d", d), busyObs[d], 16'(remainM[d] > 0));
      checkOutput($sformatf("idx%0d", d),  idxObs[d],  16'(idxM[d]));
      checkOutput($sformatf("done%0d", d), doneObs[d], 16'(doneM[d]));
    end
  endtask

  // One clock cycle: drive inputs, check req_ready, advance the model, check outputs.
  task automatic applyStimulus(input logic r, input logic g1, input logic [1:0] g2,
                               input logic m, input logic [3:0] s, input logic v);
    logic en;
    @(negedge clk);
    rst_n = r; en_g1 = g1; en_g2_n = g2; mode = m; sel = s; req_valid = v;
    en = g1 & (g2 == 2'b00);
    #1;
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("ready%0d", d), readyObs[d], 16'(remainM[d] == 0 && en));
    modelEdge(r, en, m, int'(s), v);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Brief reset pulse between edges: a synchronous reset must leave outputs untouched.
  task automatic resetGlitch();
    rst_n = 1'b0;
    #2;
    checkAll();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en_g1 = 1'b1; en_g2_n = 2'b00; mode = 1'b0; sel = 4'd0; req_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      remainM[d] = 0; startM[d] = 0; totalM[d] = 0; scanM[d] = 0; idxM[d] = 0; doneM[d] = 0;
    end

    // Reset and idle
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);

    // Single strobe on line 5, then a request held off by en_g2_n
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd5, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 4'd5, 1'b1);

    // Full scan from line 6 with wrap, run to completion
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 4'd6, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);

    // Scan from line 0 aborted by dropping en_g1
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);

    // Reset glitch and synchronous reset in the middle of a strobe
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd2, 1'b1);
    resetGlitch();
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);

    // Back-to-back single requests with sel=15
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd15, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, g1, m, v;
      logic [1:0] g2;
      logic [3:0] s;
      r  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      g1 = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      g2 = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(0, 3)) : 2'b00;
      m  = 1'($urandom_range(0, 1));
      s  = 4'($urandom_range(0, 15));
      v  = 1'($urandom_range(0, 1));
      applyStimulus(r, g1, g2, m, s, v);
      if ($urandom_range(0, 99) < 2) resetGlitch();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/strobe_decoder.md
# strobe_decoder

Parametrised, registered N-line strobe decoder with the 74x138-style enable gating (one active-high and two active-low enables) of the fixed 3-to-8 benchmark decoders, plus a ready/valid request port, programmable pulse length and an auto-scan mode that walks every output line. It sits between the control logic and the select lines of peripheral banks. It replaces ad-hoc combinational decoders wherever glitch-free, timed strobes are required.

## Interface

Parameters:
- SEL_W, 3, select width; N_OUT = 2**SEL_W output lines
- PULSE_LEN, 1, cycles each line is held active (>= 1)
- ACTIVE_LOW, 1, 1: active line driven 0, idle lines 1; 0: inverse polarity

Ports:
- clk  in  1  sole clock; all state changes on its rising edge
- rst_n  in  1  synchronous, active-low reset
- en_g1  in  1  active-high enable
- en_g2_n  in  2  active-low enables; both bits must be 0
- mode  in  1  0 = SINGLE, 1 = SCAN; sampled at acceptance
- sel  in  SEL_W  target line (SINGLE) or start line (SCAN); sampled at acceptance
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- y  out  N_OUT  registered strobe outputs
- busy  out  1  high while a strobe sequence runs
- idx  out  SEL_W  line currently strobed (last strobed when idle)
- done  out  1  one-cycle pulse on normal completion

## Operation

- enable = en_g1 & ~en_g2_n[0] & ~en_g2_n[1], evaluated every cycle.
- req_ready = (state == IDLE) & enable; combinational. Requests stall while disabled.
- States: IDLE, STROBE, SCAN.
- IDLE: y all inactive. Accept -> idx <= sel, pulse counter <= 0. mode 0 -> STROBE; mode 1 -> SCAN with step counter <= 0.
- STROBE: y[idx] active, others inactive. After PULSE_LEN cycles -> IDLE, done pulses.
- SCAN: y[idx] active for PULSE_LEN cycles, then idx <= idx + 1 mod N_OUT (wrap from N_OUT-1 to 0). After N_OUT lines have been strobed -> IDLE, done pulses. Every line is strobed exactly once, starting at sel.
- Enable drop in STROBE or SCAN: abort. Next edge -> IDLE, y inactive, no done pulse. idx holds the aborted line.
- Exactly one line is active at any time. No cycle has zero active lines between SCAN steps.
- Width rules: pulse counter is $clog2(PULSE_LEN+1) bits; step counter is SEL_W+1 bits, so a count of N_OUT is representable. idx wraps modulo 2**SEL_W.
- Reset: state IDLE; y all inactive (all ones if ACTIVE_LOW, else all zeros); busy 0; done 0; idx 0. Reset mid-sequence takes priority over all other events. No done pulse is generated.

## Timing

- Acceptance at edge k: y, busy and idx are valid after edge k (1-cycle latency). All outputs are registered; y is glitch-free.
- SINGLE: line active for cycles k+1 .. k+PULSE_LEN. done is high in cycle k+PULSE_LEN+1, with y inactive, busy 0 and req_ready possibly 1 in the same cycle.
- SCAN: total active time N_OUT*PULSE_LEN cycles. done is high in the cycle after the last line.
- Back-to-back: a new request can be accepted in the done cycle. Minimum period is PULSE_LEN+1 (SINGLE).
- Enable falling in cycle c during a sequence: y is inactive from cycle c+1.

## Structure

- Package strobe_decoder_pkg holds:
  - state enum (IDLE, STROBE, SCAN)
  - MODE_SINGLE/MODE_SCAN constants
  - polarity helper function
- Sub-module onehot_decoder: combinational SEL_W -> N_OUT one-hot with an ACTIVE_LOW parameter and an enable input. It is instantiated once, and its output is registered in the parent.

## Test plan

- Reset, defaults (SEL_W=3, PULSE_LEN=1, ACTIVE_LOW=1): y=8'hFF, busy=0, done=0, idx=0. req_ready=1 with en_g1=1, en_g2_n=2'b00.
- SINGLE, sel=5: y=8'hDF for exactly one cycle, then 8'hFF. done pulses once. Repeat with en_g2_n=2'b01: req_ready=0, request held, y stays 8'hFF.
- SCAN, sel=6, PULSE_LEN=2: idx sequence 6,6,7,7,0,0,...,5,5 (16 cycles, wrap 7->0). done is high in cycle 17 after acceptance.
- Abort: SCAN from sel=0, drop en_g1 while idx=3. Next cycle y=8'hFF, busy=0, idx=3, done never asserts.
- Sync reset mid-STROBE (PULSE_LEN=4, cycle 2): outputs return to reset values at the next edge, no done. Reset asserted without a clock edge has no effect.
- ACTIVE_LOW=0, SEL_W=4: SINGLE sel=15 -> y=16'h8000 for one cycle. Back-to-back request in the done cycle is accepted.
